arbitro_posicao: RTL and testbench
==================================

ARBITRO_POSICAO -- requirements
Module: arbitro_posicao

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 4, consecutive stable cycles required to accept a button level change.
REQ-002 Parameter TIMEOUT_CICLOS, default 1000, maximum movement cycles before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SinalBotao1  input  1  raw asynchronous button, requests position 1.
REQ-006 SinalBotao2  input  1  raw asynchronous button, requests position 2.
REQ-007 fimCurso1  input  1  raw limit switch, 1 = mechanism at position 1.
REQ-008 fimCurso2  input  1  raw limit switch, 1 = mechanism at position 2.
REQ-009 motor1  output  1  registered; drive toward position 1.
REQ-010 motor2  output  1  registered; drive toward position 2.
REQ-011 posicaofinal  output  1  registered; last completed position, 0 = pos 1, 1 = pos 2.
REQ-012 ocupado  output  1  registered; 1 while in MOVE1 or MOVE2.
REQ-013 erro  output  1  registered; 1 while in ERRO.

Function
REQ-014 All four raw inputs SHALL pass a 2-FF synchronizer; limit switches are not debounced.
REQ-015 Each synchronized button SHALL have a debouncer: debounced level flips only after sync value differs from it for DEBOUNCE_CICLOS consecutive cycles; a differing-run break restarts the count.
REQ-016 A rising edge of a debounced level SHALL produce a one-cycle request pulse req1/req2.
REQ-017 FSM states: PARADO, MOVE1, MOVE2, ERRO; motor1 = (MOVE1), motor2 = (MOVE2), never both high.
REQ-018 PARADO, req1 only: if synced fimCurso1 = 1 drop request, else go MOVE1 next edge; req2 symmetric.
REQ-019 PARADO, req1 and req2 same cycle: grant position opposite to posicaofinal; if that limit already asserted, grant the other; if both limits asserted, go ERRO.
REQ-020 MOVE1: synced fimCurso1 = 1 -> PARADO next edge, posicaofinal <= 0; MOVE2 symmetric with posicaofinal <= 1.
REQ-021 Movement counter SHALL clear on entering MOVEx and increment each MOVEx cycle; reaching TIMEOUT_CICLOS without target limit -> ERRO.
REQ-022 Synced fimCurso1 and fimCurso2 both 1 in any state except ERRO -> ERRO next edge (highest priority).
REQ-023 Requests during MOVEx SHALL be held in one pending slot: request for the opposite position stored (overwrites), same-position request dropped.
REQ-024 On returning to PARADO with pending set, pending SHALL be served by REQ-018 rules on the following cycle, then cleared.
REQ-025 Latency: motor output rises at edge k+DEBOUNCE_CICLOS+3, where k is the first edge sampling raw button high (input held stable).
REQ-026 Latency: motor output falls 3 edges after the first edge sampling raw target limit high.
REQ-027 ERRO: motors off, erro = 1, requests and pending discarded; exit only via reset.

Reset
REQ-028 reset = 1 at an edge SHALL force PARADO, motor1 = motor2 = 0, posicaofinal = 0, ocupado = 0, erro = 0, pending, counters, synchronizers and debounced levels cleared to 0.
REQ-029 Reset mid-movement SHALL stop the motor on that same edge; reset overrides every other condition.

Verification (DEBOUNCE_CICLOS = 4, TIMEOUT_CICLOS = 20)
REQ-030 Botao2 held high from edge 10, fimCurso2 raised at edge 30 -> motor2 high edges 17..32, ocupado same, posicaofinal = 1 from edge 33.
REQ-031 Botao1 glitch high for 3 cycles -> no request, motors stay 0.
REQ-032 Both buttons rise same edge with posicaofinal = 0, fimCurso1 = 1 -> MOVE2 granted, motor1 never asserted.
REQ-033 Botao2 pressed, fimCurso2 never asserted -> after 20 motor2 cycles erro = 1, motors 0; further presses ignored until reset.
REQ-034 During MOVE2, press Botao1 -> after fimCurso2 completes, PARADO one cycle, then motor1 asserts.
REQ-035 Reset asserted mid MOVE1 -> next edge all outputs 0, state PARADO; fimCurso1 and fimCurso2 both high -> erro = 1 within 3 edges.

Source files
------------

// File: rtl/arbitro_posicao.sv
// ---------------------------------------------------------------------------
// arbitro_posicao
// Arbitrates a two-position mechanism driven by two push buttons and two
// limit switches. Buttons are synchronized and debounced, and their rising
// edges become one-cycle requests. An FSM moves the mechanism toward the
// requested position, remembers one request arriving mid-movement, and locks
// into an error state on a movement timeout or when both limit switches read
// active at once.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   SinalBotao1  : raw button, requests position 1
//   SinalBotao2  : raw button, requests position 2
//   fimCurso1    : raw limit switch, 1 = mechanism at position 1
//   fimCurso2    : raw limit switch, 1 = mechanism at position 2
//   motor1       : drive toward position 1 (registered)
//   motor2       : drive toward position 2 (registered)
//   posicaofinal : last completed position, 0 = pos 1, 1 = pos 2 (registered)
//   ocupado      : 1 while moving (registered)
//   erro         : 1 while in the error state (registered)
// ---------------------------------------------------------------------------
module arbitro_posicao #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int TIMEOUT_CICLOS  = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic SinalBotao1,
   input  logic SinalBotao2,
   input  logic fimCurso1,
   input  logic fimCurso2,
   output logic motor1,
   output logic motor2,
   output logic posicaofinal,
   output logic ocupado,
   output logic erro
);

   localparam int DB_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam int TO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CICLOS - 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CICLOS - 1);

   localparam logic [1:0] PARADO = 2'd0;
   localparam logic [1:0] MOVE1  = 2'd1;
   localparam logic [1:0] MOVE2  = 2'd2;
   localparam logic [1:0] ERRO   = 2'd3;

   // Bit order in the synchronizer: {fimCurso2, fimCurso1, botao2, botao1}
   logic [3:0]      r_sync1;
   logic [3:0]      r_sync2;
   logic [DB_W-1:0] r_dbCnt [2];
   logic [1:0]      r_deb;
   logic [1:0]      r_debAnt;
   logic [1:0]      r_estado;
   logic [TO_W-1:0] r_cnt;
   logic            r_pos;
   logic            r_pendVal;
   logic            r_pendPos;

   logic [1:0] w_req;
   logic       w_fim1;
   logic       w_fim2;
   logic       w_ambosFim;
   logic       w_quer1;
   logic       w_quer2;

   // Two-flop synchronizer for all four raw inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {fimCurso2, fimCurso1, SinalBotao2, SinalBotao1};
         r_sync2 <= r_sync1;
      end
   end

   // Button debouncers: the debounced level only follows the synchronized
   // level after it has differed for DEBOUNCE_CICLOS consecutive cycles;
   // any cycle of agreement restarts the run
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dbCnt[0] <= '0;
         r_dbCnt[1] <= '0;
         r_deb      <= '0;
         r_debAnt   <= '0;
      end else begin
         r_debAnt <= r_deb;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_dbCnt[i] <= '0;
            end else if (r_dbCnt[i] == DB_MAX) begin
               r_deb[i]   <= r_sync2[i];
               r_dbCnt[i] <= '0;
            end else begin
               r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
            end
         end
      end
   end

   // Request pulses and effective requests while idle; a stored pending
   // request counts as if its button had just been pressed
   always_comb begin
      w_req      = r_deb & ~r_debAnt;
      w_fim1     = r_sync2[2];
      w_fim2     = r_sync2[3];
      w_ambosFim = w_fim1 & w_fim2;
      w_quer1    = w_req[0] | (r_pendVal & ~r_pendPos);
      w_quer2    = w_req[1] | (r_pendVal & r_pendPos);
   end

   // Main FSM; the movement counter is held at zero while idle so it is
   // already clear on entry to either MOVE state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado  <= PARADO;
         r_cnt     <= '0;
         r_pos     <= 1'b0;
         r_pendVal <= 1'b0;
         r_pendPos <= 1'b0;
      end else begin
         case (r_estado)
            PARADO: begin
               r_pendVal <= 1'b0;
               r_cnt     <= '0;
               if (w_ambosFim) begin
                  r_estado <= ERRO;
               end else if (w_quer1 && w_quer2) begin
                  if (!r_pos) begin
                     r_estado <= w_fim2 ? MOVE1 : MOVE2;
                  end else begin
                     r_estado <= w_fim1 ? MOVE2 : MOVE1;
                  end
               end else if (w_quer1 && !w_fim1) begin
                  r_estado <= MOVE1;
               end else if (w_quer2 && !w_fim2) begin
                  r_estado <= MOVE2;
               end
            end
            MOVE1: begin
               if (w_req[1]) begin
                  r_pendVal <= 1'b1;
                  r_pendPos <= 1'b1;
               end
               if (w_ambosFim) begin
                  r_estado  <= ERRO;
                  r_pendVal <= 1'b0;
               end else if (w_fim1) begin
                  r_estado <= PARADO;
                  r_pos    <= 1'b0;
               end else if (r_cnt == TO_MAX) begin
                  r_estado  <= ERRO;
                  r_pendVal <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            MOVE2: begin
               if (w_req[0]) begin
                  r_pendVal <= 1'b1;
                  r_pendPos <= 1'b0;
               end
               if (w_ambosFim) begin
                  r_estado  <= ERRO;
                  r_pendVal <= 1'b0;
               end else if (w_fim2) begin
                  r_estado <= PARADO;
                  r_pos    <= 1'b1;
               end else if (r_cnt == TO_MAX) begin
                  r_estado  <= ERRO;
                  r_pendVal <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ERRO: begin
               r_pendVal <= 1'b0;
            end
            default: begin
               r_estado <= PARADO;
            end
         endcase
      end
   end

   // Output registers follow the FSM by one cycle, which gives the
   // press-to-motor and limit-to-stop latencies; reset clears them on the
   // same edge so a running motor stops immediately
   always_ff @(posedge clk) begin
      if (reset) begin
         motor1       <= 1'b0;
         motor2       <= 1'b0;
         posicaofinal <= 1'b0;
         ocupado      <= 1'b0;
         erro         <= 1'b0;
      end else begin
         motor1       <= (r_estado == MOVE1);
         motor2       <= (r_estado == MOVE2);
         posicaofinal <= r_pos;
         ocupado      <= (r_estado == MOVE1) || (r_estado == MOVE2);
         erro         <= (r_estado == ERRO);
      end
   end

endmodule

// File: tb/tb_arbitro_posicao.sv
// ---------------------------------------------------------------------------
// tb_arbitro_posicao
// Directed testbench for arbitro_posicao with DEBOUNCE_CICLOS = 4 and
// TIMEOUT_CICLOS = 20. Edges are numbered from the first edge after reset
// is released; an input set before edge e is first sampled at edge e, and
// outputs are read 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_arbitro_posicao;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic SinalBotao1 = 1'b0;
   logic SinalBotao2 = 1'b0;
   logic fimCurso1 = 1'b0;
   logic fimCurso2 = 1'b0;
   logic motor1;
   logic motor2;
   logic posicaofinal;
   logic ocupado;
   logic erro;

   int checkCount = 0;
   int errorCount = 0;
   int edgeCnt    = 0;

   arbitro_posicao #(
      .DEBOUNCE_CICLOS(4),
      .TIMEOUT_CICLOS (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .SinalBotao1 (SinalBotao1),
      .SinalBotao2 (SinalBotao2),
      .fimCurso1   (fimCurso1),
      .fimCurso2   (fimCurso2),
      .motor1      (motor1),
      .motor2      (motor2),
      .posicaofinal(posicaofinal),
      .ocupado     (ocupado),
      .erro        (erro)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Drive the raw inputs for the next edge, then advance past that edge
   task automatic applyStimulus(input logic nb1, input logic nb2,
                                input logic nf1, input logic nf2);
      SinalBotao1 = nb1;
      SinalBotao2 = nb2;
      fimCurso1   = nf1;
      fimCurso2   = nf2;
      @(posedge clk);
      edgeCnt++;
      #1;
   endtask

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold reset for two edges with all inputs low, then restart numbering
   task automatic resetDut();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      edgeCnt = 0;
   endtask

   // Directed scenarios, each preceded by a reset
   initial begin
      $display("[TB] start");

      resetDut();
      checkOutput("reset_outputs", {27'd0, motor1, motor2, posicaofinal, ocupado, erro}, 32'd0);

      // Button 2 held from edge 10, limit 2 from edge 30
      resetDut();
      for (int e = 1; e <= 36; e++) begin
         applyStimulus(1'b0, e >= 10, 1'b0, e >= 30);
         checkOutput($sformatf("mv2_motor2_e%0d", e), {31'd0, motor2}, {31'd0, (e >= 17 && e <= 32)});
         checkOutput($sformatf("mv2_ocupado_e%0d", e), {31'd0, ocupado}, {31'd0, (e >= 17 && e <= 32)});
         checkOutput($sformatf("mv2_pos_e%0d", e), {31'd0, posicaofinal}, {31'd0, (e >= 33)});
         checkOutput($sformatf("mv2_motor1_e%0d", e), {31'd0, motor1}, 32'd0);
      end

      // Three-cycle glitch on button 1 must be filtered
      resetDut();
      for (int e = 1; e <= 20; e++) begin
         applyStimulus(e >= 3 && e <= 5, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("glitch_e%0d", e), {29'd0, motor1, motor2, ocupado}, 32'd0);
      end

      // Exactly four cycles high is accepted: motor1 at edge 3+4+3
      resetDut();
      for (int e = 1; e <= 14; e++) begin
         applyStimulus(e >= 3 && e <= 6, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("pulse4_motor1_e%0d", e), {31'd0, motor1}, {31'd0, (e >= 10)});
      end

      // Request for a position already reached is dropped
      resetDut();
      for (int e = 1; e <= 16; e++) begin
         applyStimulus(e >= 3, 1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("atpos1_e%0d", e), {30'd0, motor1, ocupado}, 32'd0);
      end

      // Both buttons together, posicaofinal = 0, limit 1 active -> MOVE2
      resetDut();
      for (int e = 1; e <= 14; e++) begin
         applyStimulus(e >= 5, e >= 5, 1'b1, 1'b0);
         checkOutput($sformatf("both_motor1_e%0d", e), {31'd0, motor1}, 32'd0);
         checkOutput($sformatf("both_motor2_e%0d", e), {31'd0, motor2}, {31'd0, (e >= 12)});
      end

      // Movement timeout: 20 motor cycles, then error until reset
      resetDut();
      for (int e = 1; e <= 32; e++) begin
         applyStimulus(1'b0, e >= 2, 1'b0, 1'b0);
         checkOutput($sformatf("tmo_motor2_e%0d", e), {31'd0, motor2}, {31'd0, (e >= 9 && e <= 28)});
         checkOutput($sformatf("tmo_erro_e%0d", e), {31'd0, erro}, {31'd0, (e >= 29)});
      end
      for (int e = 33; e <= 55; e++) begin
         applyStimulus(e >= 42, e >= 40, 1'b0, 1'b0);
         checkOutput($sformatf("tmo_locked_e%0d", e), {29'd0, motor1, motor2, ocupado}, 32'd0);
         checkOutput($sformatf("tmo_erro_e%0d", e), {31'd0, erro}, 32'd1);
      end
      resetDut();
      checkOutput("tmo_erro_cleared", {31'd0, erro}, 32'd0);

      // Button 1 pressed during MOVE2 is served after one idle cycle
      resetDut();
      for (int e = 1; e <= 36; e++) begin
         applyStimulus(e >= 12 && e < 30, e >= 2 && e < 15, e >= 30, e >= 22 && e < 27);
         checkOutput($sformatf("pend_motor2_e%0d", e), {31'd0, motor2}, {31'd0, (e >= 9 && e <= 24)});
         checkOutput($sformatf("pend_motor1_e%0d", e), {31'd0, motor1}, {31'd0, (e >= 26 && e <= 32)});
         checkOutput($sformatf("pend_pos_e%0d", e), {31'd0, posicaofinal}, {31'd0, (e >= 25 && e <= 32)});
         checkOutput($sformatf("pend_ocupado_e%0d", e), {31'd0, ocupado},
                     {31'd0, ((e >= 9 && e <= 24) || (e >= 26 && e <= 32))});
      end

      // Reset in the middle of MOVE1, then both limits active
      resetDut();
      for (int e = 1; e <= 11; e++) begin
         applyStimulus(e >= 2, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("rst_motor1_e%0d", e), {31'd0, motor1}, {31'd0, (e >= 9)});
      end
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_mid_outputs", {27'd0, motor1, motor2, posicaofinal, ocupado, erro}, 32'd0);
      reset = 1'b0;
      for (int e = 13; e <= 20; e++) begin
         applyStimulus(1'b0, 1'b0, e >= 15, e >= 15);
         checkOutput($sformatf("rst_motors_e%0d", e), {30'd0, motor1, motor2}, 32'd0);
         checkOutput($sformatf("rst_erro_e%0d", e), {31'd0, erro}, {31'd0, (e >= 18)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
